// File: rtl/cpram_sclk_1w2r_pkg.sv
// Shared types and helpers for the 1-write / 2-read combi RAM.
// Holds the FSM state encoding and the array depth function.
package cpram_sclk_1w2r_pkg;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   function automatic int unsigned depth(input int unsigned aw);
      return 32'd1 << aw;
   endfunction

endpackage

// File: rtl/cpram_bank_1w1r.sv
// One storage bank: one write port, one registered read port.
// Ports: clk, rst (async low, read reg only), we/waddr/wdata, re/raddr/rdata.
import cpram_sclk_1w2r_pkg::*;

module cpram_bank_1w1r #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   localparam int unsigned DEPTH = depth(ADDR_WIDTH);

   logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
   logic [DATA_WIDTH-1:0] r_q;

   // storage has no reset; only the clear sweep initialises it
   always_ff @(posedge clk) begin
      if (we) r_mem[waddr] <= wdata;
   end

   // read-before-write: same-edge write is not visible here
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)    r_q <= '0;
      else if (re) r_q <= r_mem[raddr];
   end

   assign rdata = r_q;

endmodule

// File: rtl/cpram_sclk_1w2r.sv
// 1-write / 2-read RAM from two replicated banks, with optional clear sweep.
// Ports: clk, rst (async low), we/waddr/wdata, re1/raddr1/rdata1,
// re2/raddr2/rdata2, busy (clear sweep running, accesses ignored).
import cpram_sclk_1w2r_pkg::*;

module cpram_sclk_1w2r #(
   parameter int ADDR_WIDTH    = 5,
   parameter int DATA_WIDTH    = 32,
   parameter int CLEAR_ON_INIT = 1,
   parameter int ENABLE_BYPASS = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re1,
   input  logic [ADDR_WIDTH-1:0] raddr1,
   output logic [DATA_WIDTH-1:0] rdata1,
   input  logic                  re2,
   input  logic [ADDR_WIDTH-1:0] raddr2,
   output logic [DATA_WIDTH-1:0] rdata2,
   output logic                  busy
);

   localparam state_t ST_RESET = (CLEAR_ON_INIT != 0) ? ST_INIT : ST_RUN;
   localparam logic   BYP      = (ENABLE_BYPASS != 0);

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_cnt;

   logic                  w_busy;
   logic                  w_we;
   logic [ADDR_WIDTH-1:0] w_waddr;
   logic [DATA_WIDTH-1:0] w_wdata;
   logic                  w_re1;
   logic                  w_re2;
   logic                  w_byp1;
   logic                  w_byp2;
   logic [DATA_WIDTH-1:0] w_bq1;
   logic [DATA_WIDTH-1:0] w_bq2;

   logic                  r_byp1;
   logic                  r_byp2;
   logic [DATA_WIDTH-1:0] r_bd1;
   logic [DATA_WIDTH-1:0] r_bd2;

   // counter wrap from all-ones ends the sweep
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_RESET;
         r_cnt   <= '0;
      end else if (r_state == ST_INIT) begin
         r_cnt <= r_cnt + 1'b1;
         if (&r_cnt) r_state <= ST_RUN;
      end
   end

   assign w_busy  = (r_state == ST_INIT);
   assign busy    = w_busy;

   assign w_we    = w_busy | we;
   assign w_waddr = w_busy ? r_cnt : waddr;
   assign w_wdata = w_busy ? '0 : wdata;

   assign w_re1   = re1 & ~w_busy;
   assign w_re2   = re2 & ~w_busy;

   assign w_byp1  = BYP & we & (raddr1 == waddr);
   assign w_byp2  = BYP & we & (raddr2 == waddr);

   // bypass flag/data shadow the bank read register of each port
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_byp1 <= 1'b0;
         r_byp2 <= 1'b0;
         r_bd1  <= '0;
         r_bd2  <= '0;
      end else begin
         if (w_re1) begin
            r_byp1 <= w_byp1;
            if (w_byp1) r_bd1 <= wdata;
         end
         if (w_re2) begin
            r_byp2 <= w_byp2;
            if (w_byp2) r_bd2 <= wdata;
         end
      end
   end

   cpram_bank_1w1r #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH)
   ) u_bank1 (
      .clk  (clk),
      .rst  (rst),
      .we   (w_we),
      .waddr(w_waddr),
      .wdata(w_wdata),
      .re   (w_re1),
      .raddr(raddr1),
      .rdata(w_bq1)
   );

   cpram_bank_1w1r #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH)
   ) u_bank2 (
      .clk  (clk),
      .rst  (rst),
      .we   (w_we),
      .waddr(w_waddr),
      .wdata(w_wdata),
      .re   (w_re2),
      .raddr(raddr2),
      .rdata(w_bq2)
   );

   assign rdata1 = r_byp1 ? r_bd1 : w_bq1;
   assign rdata2 = r_byp2 ? r_bd2 : w_bq2;

endmodule

// File: tb/tb_cpram_sclk_1w2r.sv
// Directed bench for cpram_sclk_1w2r.
// Runs a bypass and a no-bypass instance side by side.
module tb_cpram_sclk_1w2r;

   logic        clk = 1'b0;
   logic        rst;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic        re1;
   logic [4:0]  raddr1;
   logic        re2;
   logic [4:0]  raddr2;

   logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
   logic        busy_b, busy_n;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   cpram_sclk_1w2r #(
      .ADDR_WIDTH(5), .DATA_WIDTH(32),
      .CLEAR_ON_INIT(1), .ENABLE_BYPASS(1)
   ) dut (
      .clk(clk), .rst(rst),
      .we(we), .waddr(waddr), .wdata(wdata),
      .re1(re1), .raddr1(raddr1), .rdata1(rd1_b),
      .re2(re2), .raddr2(raddr2), .rdata2(rd2_b),
      .busy(busy_b)
   );

   cpram_sclk_1w2r #(
      .ADDR_WIDTH(5), .DATA_WIDTH(32),
      .CLEAR_ON_INIT(1), .ENABLE_BYPASS(0)
   ) dut_nb (
      .clk(clk), .rst(rst),
      .we(we), .waddr(waddr), .wdata(wdata),
      .re1(re1), .raddr1(raddr1), .rdata1(rd1_n),
      .re2(re2), .raddr2(raddr2), .rdata2(rd2_n),
      .busy(busy_n)
   );

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we = 0; re1 = 0; re2 = 0;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      idle();
      we = 1; waddr = a; wdata = d;
      tick();
      we = 0;
   endtask

   task automatic count_busy(input string tag);
      int n;
      n = 0;
      while (busy_b && n < 100) begin
         check({tag, "_rd1_sweep"}, rd1_b, 32'h0);
         tick();
         n++;
      end
      check({tag, "_cycles"}, n, 32);
      check({tag, "_nb_busy"}, {31'b0, busy_n}, 32'h0);
   endtask

   initial begin
      rst = 0;
      idle();
      waddr = 0; wdata = 0; raddr1 = 0; raddr2 = 0;
      tick();
      tick();
      check("rst_busy", {31'b0, busy_b}, 32'h1);
      check("rst_rd1", rd1_b, 32'h0);
      check("rst_rd2", rd2_b, 32'h0);

      rst = 1;
      count_busy("sweep1");

      for (int a = 0; a < 32; a++) begin
         re1 = 1; re2 = 1;
         raddr1 = 5'(a); raddr2 = 5'(31 - a);
         tick();
         check("clr_rd1", rd1_b, 32'h0);
         check("clr_rd2", rd2_b, 32'h0);
         check("clr_nb_rd1", rd1_n, 32'h0);
      end
      idle();

      wr(5'd3, 32'hDEADBEEF);
      re1 = 1; re2 = 1; raddr1 = 3; raddr2 = 3;
      tick();
      idle();
      check("a3_rd1", rd1_b, 32'hDEADBEEF);
      check("a3_rd2", rd2_b, 32'hDEADBEEF);
      check("a3_nb_rd1", rd1_n, 32'hDEADBEEF);

      wr(5'd7, 32'h11);
      wr(5'd8, 32'h88);
      we = 1; waddr = 7; wdata = 32'h22;
      re1 = 1; raddr1 = 7; re2 = 1; raddr2 = 8;
      tick();
      idle();
      check("byp_rd1", rd1_b, 32'h22);
      check("nobyp_rd1", rd1_n, 32'h11);
      check("byp_rd2", rd2_b, 32'h88);
      check("nobyp_rd2", rd2_n, 32'h88);

      re1 = 1; raddr1 = 7;
      tick();
      idle();
      check("a7_after_nb", rd1_n, 32'h22);

      we = 1; waddr = 9; wdata = 32'h99;
      re1 = 1; re2 = 1; raddr1 = 9; raddr2 = 9;
      tick();
      idle();
      check("same_byp_rd1", rd1_b, 32'h99);
      check("same_byp_rd2", rd2_b, 32'h99);
      check("same_nb_rd1", rd1_n, 32'h0);
      check("same_nb_rd2", rd2_n, 32'h0);

      wr(5'd10, 32'h55);
      re1 = 1; raddr1 = 10;
      tick();
      idle();
      check("hold_init", rd1_b, 32'h55);
      for (int i = 0; i < 5; i++) begin
         we = 1; waddr = 10; wdata = 32'hAA + i;
         raddr1 = 10;
         tick();
         check("hold_rd1", rd1_b, 32'h55);
         check("hold_nb_rd1", rd1_n, 32'h55);
      end
      idle();
      re1 = 1; raddr1 = 10;
      tick();
      idle();
      check("hold_after", rd1_b, 32'hAE);

      wr(5'd31, 32'h1234);
      re2 = 1; raddr2 = 31;
      tick();
      idle();
      check("a31_pre", rd2_b, 32'h1234);

      rst = 0;
      tick();
      check("rst2_rd1", rd1_b, 32'h0);
      check("rst2_rd2", rd2_b, 32'h0);
      rst = 1;
      for (int i = 0; i < 10; i++) tick();
      check("mid_busy", {31'b0, busy_b}, 32'h1);
      rst = 0;
      tick(); tick(); tick();
      rst = 1;
      we = 1; waddr = 31; wdata = 32'hFF;
      re1 = 1; raddr1 = 31;
      count_busy("sweep2");
      idle();
      check("sweep2_rd1", rd1_b, 32'h0);

      re1 = 1; re2 = 1; raddr1 = 31; raddr2 = 10;
      tick();
      idle();
      check("a31_clr_rd1", rd1_b, 32'h0);
      check("a10_clr_rd2", rd2_b, 32'h0);
      check("a31_nb_rd1", rd1_n, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
